ysyx_22040895_muldiv: RTL and testbench
=======================================

YSYX_22040895_MULDIV -- requirements
Module: ysyx_22040895_muldiv

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, operand and result width.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port valid_i_muldiv, input, 1, request valid from the operand-select stage.
REQ-005 The block SHALL have port ready_o_muldiv, output, 1, block can accept a request.
REQ-006 The block SHALL have port op_i_muldiv, input, 3, RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 The block SHALL have port word_i_muldiv, input, 1, 32-bit W-variant select.
REQ-008 The block SHALL have ports opnum1_i_muldiv and opnum2_i_muldiv, input, XLEN, operands (rs1 and rs2 values from operand select).
REQ-009 The block SHALL have port flush_i_muldiv, input, 1, abort the current operation.
REQ-010 The block SHALL have port out_valid_o_muldiv, output, 1, result valid.
REQ-011 The block SHALL have port out_ready_i_muldiv, input, 1, consumer accepts result.
REQ-012 The block SHALL have port result_o_muldiv, output, XLEN, result.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE; ready_o_muldiv SHALL be 1 exactly when the state is IDLE.
REQ-014 On a clk edge with valid and ready both high, the block SHALL latch op, word flag and operands; the request is accepted on that edge.
REQ-015 With word=1, the operands SHALL be the low 32 bits, sign-extended (signed ops) or zero-extended (unsigned ops); result = low 32 bits of the result, sign-extended to XLEN.
REQ-016 With word=1, MULH, MULHSU and MULHU SHALL behave as MULW.
REQ-017 Normal ops SHALL go IDLE->CALC and perform one shift-add (multiply) or restoring-subtract (divide) iteration per cycle on operand magnitudes, with sign applied at completion.
- Iteration count K = 64 (word=0) or 32 (word=1).
REQ-018 After the Kth CALC cycle, the state SHALL go CALC->DONE; out_valid first goes high in cycle K+1 after the accept edge.
REQ-019 Division with divisor zero (after word masking) SHALL skip CALC and go IDLE->DONE; out_valid first high in cycle 1 after the accept edge.
- Quotient = all ones; remainder = dividend.
REQ-020 Signed overflow (dividend = most negative value, divisor = -1) SHALL skip CALC the same way.
- Quotient = dividend; remainder = 0.
REQ-021 The MUL result SHALL be the low XLEN bits of the product; MULH/MULHSU/MULHU SHALL return the high XLEN bits of the 2*XLEN product under their signedness.
REQ-022 Remainder sign SHALL follow the dividend; quotient SHALL truncate toward zero.
REQ-023 In DONE, out_valid SHALL stay 1 and result_o SHALL stay stable until out_ready=1 is sampled; the state then goes DONE->IDLE on that edge.
REQ-024 A new request SHALL NOT be accepted in the DONE cycle (ready=0).
REQ-025 result_o_muldiv SHALL be 0 whenever out_valid is 0.
REQ-026 flush=1 sampled in any state SHALL force IDLE on that edge, with out_valid=0 next cycle and no result delivered.
REQ-027 When flush and valid are both high in IDLE, flush SHALL win and no request SHALL be accepted.
REQ-028 A flush coinciding with the out handshake in DONE SHALL still count as a completed transfer; the state returns to IDLE.

Reset
REQ-029 rst=1 sampled SHALL override flush and valid.
REQ-030 In the cycle after rst=1 is sampled: state IDLE, ready_o=1, out_valid=0, result_o=0, counter and datapath registers 0.
REQ-031 Reset mid-CALC or in DONE SHALL discard the operation with no result delivered.

Verification
REQ-032 MUL: opnum1=3, opnum2=0xFFFF_FFFF_FFFF_FFFB, word=0 -> out_valid rises 65 cycles after accept with result 0xFFFF_FFFF_FFFF_FFF1.
REQ-033 MULW: opnum1=0x7FFF_FFFF, opnum2=2 -> result 0xFFFF_FFFF_FFFF_FFFE at 33 cycles.
REQ-034 Divide-by-zero: DIVU 7/0 -> 0xFFFF_FFFF_FFFF_FFFF at 1 cycle; REMU 7/0 -> 7 at 1 cycle.
REQ-035 Overflow: DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0; both at 1 cycle.
REQ-036 DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-037 Backpressure/flush:
- out_ready held 0 for 5 cycles in DONE -> out_valid and result held, ready_o=0.
- flush at CALC cycle 10 -> IDLE next cycle, no out_valid; the next request completes normally.
- rst mid-CALC -> REQ-030 values.

Source files
------------

// File: rtl/ysyx_22040895_muldiv.sv
// rtl/ysyx_22040895_muldiv.sv - iterative RV64M multiply/divide unit
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, sign fixed at completion.
module ysyx_22040895_muldiv #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i_muldiv,
  output logic            ready_o_muldiv,
  input  logic [2:0]      op_i_muldiv,
  input  logic            word_i_muldiv,
  input  logic [XLEN-1:0] opnum1_i_muldiv,
  input  logic [XLEN-1:0] opnum2_i_muldiv,
  input  logic            flush_i_muldiv,
  output logic            out_valid_o_muldiv,
  input  logic            out_ready_i_muldiv,
  output logic [XLEN-1:0] result_o_muldiv
);

  localparam int W2 = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q;
  logic [W2-1:0]   prod_q;
  logic [5:0]      cnt_q;
  logic            word_q, is_div_q, is_rem_q, hi_q, neg_q;

  logic            sign_a, sign_b, a_neg, b_neg, div_zero, div_ovf, special, accept, last_iter;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;

  assign sign_a = op_i_muldiv[2] ? ~op_i_muldiv[0] : (op_i_muldiv != 3'd3);
  assign sign_b = op_i_muldiv[2] ? ~op_i_muldiv[0] : ~op_i_muldiv[1];
  assign a_ext  = word_i_muldiv ? {{(XLEN-32){sign_a & opnum1_i_muldiv[31]}}, opnum1_i_muldiv[31:0]}
                                : opnum1_i_muldiv;
  assign b_ext  = word_i_muldiv ? {{(XLEN-32){sign_b & opnum2_i_muldiv[31]}}, opnum2_i_muldiv[31:0]}
                                : opnum2_i_muldiv;
  assign a_neg  = sign_a & a_ext[XLEN-1];
  assign b_neg  = sign_b & b_ext[XLEN-1];
  assign a_mag  = a_neg ? -a_ext : a_ext;
  assign b_mag  = b_neg ? -b_ext : b_ext;

  // Sign-extended operands make the W-variant overflow check a 32-bit compare
  assign div_zero = op_i_muldiv[2] & (b_ext == '0);
  assign div_ovf  = op_i_muldiv[2] & ~op_i_muldiv[0] & (b_ext == '1) &
                    (word_i_muldiv ? (a_ext[31:0] == 32'h8000_0000) : (a_ext == MIN_NEG));
  assign special  = div_zero | div_ovf;
  assign accept   = (state_q == IDLE) & valid_i_muldiv & ~flush_i_muldiv;
  assign last_iter = (cnt_q == (word_q ? 6'd31 : 6'd63));

  // One iteration of each algorithm; prod_q holds {hi, lo} for both
  logic [XLEN:0]   add_sum, sh_hi;
  logic [XLEN-1:0] diff;
  logic            ge;
  logic [W2-1:0]   mul_next, div_next;

  assign add_sum  = {1'b0, prod_q[W2-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {add_sum, prod_q[XLEN-1:1]};
  assign sh_hi    = prod_q[W2-1:XLEN-1];
  assign ge       = (sh_hi >= {1'b0, a_q});
  assign diff     = sh_hi[XLEN-1:0] - a_q;
  assign div_next = {ge ? diff : sh_hi[XLEN-1:0], prod_q[XLEN-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (flush_i_muldiv) state_d = IDLE;
            else if (last_iter) state_d = DONE;
      DONE: if (flush_i_muldiv || out_ready_i_muldiv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      word_q   <= 1'b0;
      is_div_q <= 1'b0;
      is_rem_q <= 1'b0;
      hi_q     <= 1'b0;
      neg_q    <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      word_q   <= word_i_muldiv;
      is_div_q <= op_i_muldiv[2];
      is_rem_q <= op_i_muldiv[1];
      hi_q     <= ~op_i_muldiv[2] & ~word_i_muldiv & (op_i_muldiv[1:0] != 2'd0);
      neg_q    <= special ? 1'b0 : ((op_i_muldiv[2] & op_i_muldiv[1]) ? a_neg : (a_neg ^ b_neg));
      if (div_zero) begin
        a_q    <= '0;
        prod_q <= {a_ext, {XLEN{1'b1}}};
      end else if (div_ovf) begin
        a_q    <= '0;
        prod_q <= {{XLEN{1'b0}}, a_ext};
      end else if (op_i_muldiv[2]) begin
        // W divides run 32 steps, so the dividend starts at the top of lo
        a_q    <= b_mag;
        prod_q <= {{XLEN{1'b0}}, word_i_muldiv ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag};
      end else begin
        a_q    <= a_mag;
        prod_q <= {{XLEN{1'b0}}, b_mag};
      end
    end else if (state_q == CALC) begin
      prod_q <= is_div_q ? div_next : mul_next;
      cnt_q  <= cnt_q + 6'd1;
    end
  end

  // A 32-step multiply leaves the product XLEN-32 bits above its natural position
  logic [W2-1:0]   full, full_s;
  logic [XLEN-1:0] mul_r, q_raw, div_r, res;

  assign full   = word_q ? (prod_q >> (XLEN - 32)) : prod_q;
  assign full_s = neg_q ? -full : full;
  assign mul_r  = hi_q ? full_s[W2-1:XLEN] : full_s[XLEN-1:0];
  assign q_raw  = is_rem_q ? prod_q[W2-1:XLEN] : prod_q[XLEN-1:0];
  assign div_r  = neg_q ? -q_raw : q_raw;

  always_comb begin
    res = is_div_q ? div_r : mul_r;
    if (word_q) res = {{(XLEN-32){res[31]}}, res[31:0]};
  end

  always_comb begin
    ready_o_muldiv     = (state_q == IDLE);
    out_valid_o_muldiv = (state_q == DONE);
    result_o_muldiv    = (state_q == DONE) ? res : '0;
  end

endmodule

// File: tb/tb_ysyx_22040895_muldiv.sv
// tb/tb_ysyx_22040895_muldiv.sv - scoreboard bench for ysyx_22040895_muldiv
module tb_ysyx_22040895_muldiv;

  logic        clk = 1'b0;
  logic        rst, valid, ready, word, flush, out_valid, out_ready;
  logic [2:0]  op;
  logic [63:0] opa, opb, result;

  always #5 clk = ~clk;

  ysyx_22040895_muldiv #(.XLEN(64)) dut (
    .clk                (clk),
    .rst                (rst),
    .valid_i_muldiv     (valid),
    .ready_o_muldiv     (ready),
    .op_i_muldiv        (op),
    .word_i_muldiv      (word),
    .opnum1_i_muldiv    (opa),
    .opnum2_i_muldiv    (opb),
    .flush_i_muldiv     (flush),
    .out_valid_o_muldiv (out_valid),
    .out_ready_i_muldiv (out_ready),
    .result_o_muldiv    (result)
  );

  typedef struct packed {
    logic [63:0] res;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];
  exp_t dropped;
  int   checks = 0;
  int   errors = 0;
  logic seen;
  logic [63:0] ra, rb;
  logic [2:0]  rop;
  logic        rw;

  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pa, pb, p;
    logic [63:0]  x, y, r;
    logic         sa, sbb;
    logic signed [63:0] sx, sy;
    sa  = (f != 3'd3) && (f != 3'd5) && (f != 3'd7);
    sbb = sa && (f != 3'd2);
    x = w ? (sa  ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]}) : a;
    y = w ? (sbb ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]}) : b;
    pa = sa  ? {{64{x[63]}}, x} : {64'b0, x};
    pb = sbb ? {{64{y[63]}}, y} : {64'b0, y};
    p  = pa * pb;
    sx = $signed(x);
    sy = $signed(y);
    case (f)
      3'd0:    r = p[63:0];
      3'd4:    r = (y == 0) ? '1 : ((x == MINV && y == '1) ? x : 64'(sx / sy));
      3'd5:    r = (y == 0) ? '1 : x / y;
      3'd6:    r = (y == 0) ? x : ((x == MINV && y == '1) ? 64'd0 : 64'(sx % sy));
      3'd7:    r = (y == 0) ? x : x % y;
      default: r = w ? p[63:0] : p[127:64];
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic logic [31:0] exp_lat(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] d;
    d = w ? {32'b0, b[31:0]} : b;
    if (f[2] && d == 0) return 1;
    if (f[2] && !f[0]) begin
      if (w && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      if (!w && a == MINV && b == '1) return 1;
    end
    return w ? 33 : 65;
  endfunction

  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] want);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("issue_ready", 64'(ready), 64'd1);
    op = f; word = w; opa = a; opb = b; valid = 1'b1;
    sb.push_back({want, exp_lat(f, w, a, b)});
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   lat;
    check_eq("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    @(negedge clk);
    lat = 1;
    if (e.lat > 1) begin
      check_eq("busy_valid", 64'(out_valid), 64'd0);
      check_eq("busy_result", result, 64'd0);
    end
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(e.lat));
    if (!out_valid) return;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_result", result, e.res);
      check_eq("hold_ready", 64'(ready), 64'd0);
    end
    check_eq("result", result, e.res);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq("ack_valid", 64'(out_valid), 64'd0);
    check_eq("ack_ready", 64'(ready), 64'd1);
  endtask

  task automatic watch_quiet(input int cycles);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = 3'd0; word = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 64'(ready), 64'd1);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", result, 64'd0);

    issue(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
    collect(5);
    issue(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    collect(0);
    issue(3'd5, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    collect(0);
    issue(3'd7, 1'b0, 64'd7, 64'd0, 64'd7);
    collect(2);
    issue(3'd4, 1'b0, MINV, 64'hFFFF_FFFF_FFFF_FFFF, MINV);
    collect(0);
    issue(3'd6, 1'b0, MINV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    collect(0);
    issue(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    collect(0);
    issue(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    collect(0);
    issue(3'd1, 1'b0, MINV, MINV, 64'h4000_0000_0000_0000);
    collect(0);
    issue(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    collect(0);
    issue(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    collect(0);
    issue(3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    collect(0);

    for (int k = 0; k < 16; k++) begin
      rop = 3'($urandom_range(0, 7));
      rw  = 1'($urandom_range(0, 1));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(40, 63);
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 60);
      issue(rop, rw, ra, rb, model(rop, rw, ra, rb));
      collect(0);
    end

    issue(3'd0, 1'b0, 64'd12345, 64'd678, 64'd8369910);
    dropped = sb.pop_front();
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_eq("flush_ready", 64'(ready), 64'd1);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    watch_quiet(70);
    check_eq("flush_no_result", 64'(seen), 64'd0);
    issue(3'd5, 1'b0, 64'd100, 64'd7, 64'd14);
    collect(0);

    @(negedge clk);
    op = 3'd0; word = 1'b0; opa = 64'd5; opb = 64'd5; valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check_eq("flush_wins_ready", 64'(ready), 64'd1);

    issue(3'd1, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h1234_5678_9ABC_DEF0, 64'd0);
    dropped = sb.pop_front();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_ready", 64'(ready), 64'd1);
    check_eq("midrst_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_result", result, 64'd0);
    watch_quiet(70);
    check_eq("midrst_no_result", 64'(seen), 64'd0);
    issue(3'd6, 1'b1, 64'hFFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    collect(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
